// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId with exception and interrupt arbitration for the M stage.
// Optional Count/Compare timer on IP[15] is enabled by defining CP0_TIMER_EN.
module cp0 #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h4252_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_adel,
  input  logic        exc_ades,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        exc_req,
  output logic [31:0] vector_pc,
  output logic [31:0] epc
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  ip;
  logic        int_req;
  logic        exc_flag;
  logic [4:0]  code_next;
  logic [31:0] epc_next;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;

  assign ip = {hw_int[5] | pending, hw_int[4:0]};

  // A Compare write in the same cycle as a match clears pending: software acknowledges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 32'h0;
      compare <= 32'h0;
      pending <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (count == compare) pending <= 1'b1;
      if (we && !exc_req) begin
        if (addr == REG_COUNT) count <= wdata;
        if (addr == REG_COMPARE) begin
          compare <= wdata;
          pending <= 1'b0;
        end
      end
    end
  end
`else
  assign ip = hw_int;
`endif

  // IP is live from the pins so an asserted line raises exc_req in the same cycle.
  assign int_req   = ie & ~exl & (|(ip & im));
  assign exc_flag  = exc_adel | exc_ades | exc_ri | exc_ov;
  assign exc_req   = int_req | (~exl & exc_flag);
  assign vector_pc = HANDLER_PC;
  assign epc_next  = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;

  always_comb begin
    code_next = 5'd0;
    if (int_req)       code_next = 5'd0;
    else if (exc_adel) code_next = 5'd4;
    else if (exc_ri)   code_next = 5'd10;
    else if (exc_ov)   code_next = 5'd12;
    else if (exc_ades) code_next = 5'd5;
  end

  // Exception entry takes precedence over both mtc0 and eret in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= 6'h0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= 5'h0;
      epc      <= 32'h0;
    end else if (exc_req) begin
      exl      <= 1'b1;
      exc_code <= code_next;
      bd       <= bd_m;
      epc      <= epc_next;
    end else begin
      if (we && addr == REG_SR) begin
        im  <= wdata[15:10];
        exl <= wdata[1];
        ie  <= wdata[0];
      end
      if (we && addr == REG_EPC) epc <= wdata;
      if (eret) exl <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      REG_SR:    rdata = {16'h0, im, 8'h0, exl, ie};
      REG_CAUSE: rdata = {bd, 15'h0, ip, 3'h0, exc_code, 2'h0};
      REG_EPC:   rdata = epc;
      REG_PRID:  rdata = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
`endif
      default:   rdata = 32'h0;
    endcase
  end

endmodule
